instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Byte-serial instruction assembler between the prefetch queue and the execution unit. It pops opcode stream bytes one per cycle and collects prefixes, opcode, ModRM, displacement and immediate fields. It presents each complete instruction to the EU as one registered record with a valid/ready handshake. It also owns the instruction pointer (PC) that tracks consumed bytes.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- prefetch_data  in  8  byte at queue head
- queue_empty  in  1  queue holds no byte
- queue_pop  out  1  consume head byte this cycle
- flush  in  1  synchronous abort (branch/interrupt), from EU
- pc_load  in  1  load PC with pc_load_value (accompanies flush)
- pc_load_value  in  16  new PC
- pc  out  16  offset of first byte of the presented/pending instruction
- instr_valid  out  1  record complete
- instr_ready  in  1  EU accepts record
- seg_override_valid / seg_override  out  1 / 2  last segment prefix: 26→DS1=3, 2E→PS=0, 36→SS=1, 3E→DS0=2
- rep  out  2  00 none, 10 REPNE (F2), 11 REP (F3)
- lock  out  1  F0 seen
- opcode  out  8
- modrm  out  8  (0 when absent)
- disp  out  16  sign-extended when 8-bit, 0 when absent
- imm  out  32  little-endian, zero-filled
- imm_size  out  3  0..4
- length  out  4  bytes consumed including prefixes, saturates at 15

## Operation
- States: S_OPCODE, S_MODRM, S_DISP0, S_DISP1, S_IMM (byte index 0..3), S_DONE.
- queue_pop = (state != S_DONE) && !queue_empty && !flush. Every pop increments the internal fetch pointer (mod 2^16) and length.
- S_OPCODE: a prefix byte updates the prefix fields and stays in S_OPCODE. Any other byte latches opcode, then goes to S_MODRM if the format decoder needs it, else to S_IMM if imm_size>0, else S_DONE.
- S_MODRM: latch modrm. Displacement rules: mod=00,rm=110 → 2 bytes; mod=01 → 1 byte; mod=10 → 2 bytes; mod=11 or other mod=00 → none. F6/F7 with reg=000 get imm 1/2 bytes; other regs get none.
- S_IMM: imm sizes come from the decoder: 1 (imm8), 2 (imm16), 3 (C8 ENTER), 4 (9A/EA far pointer).
- S_DONE: instr_valid=1. Fields are held stable. On instr_valid && instr_ready, all fields are cleared, pc takes the fetch pointer, and state goes to S_OPCODE.
- flush: highest priority. State goes to S_OPCODE, all fields clear, instr_valid drops, no pop. If pc_load is set, pc and fetch pointer both load pc_load_value; otherwise the fetch pointer resets to pc.
- queue_empty stalls in place with no state change.

## Timing
- Reset values: every output is 0 and state is S_OPCODE.
- N-byte instruction with a continuously non-empty queue: N pops on consecutive cycles, instr_valid high in the cycle after the last pop.
- Back-to-back throughput is N+1 cycles per instruction. The acceptance cycle never pops.
- flush during S_DONE with instr_ready also high: flush wins and the record is discarded.
- reset mid-instruction: immediate return to reset values, with no pop until reset is released.

## Configuration
- V30MZ_PREFIX_EN defined: prefixes merge into the record as above.
- V30MZ_PREFIX_EN undefined: prefix bytes are presented as 1-byte instructions (opcode = prefix byte, length 1). seg_override_valid, rep and lock are tied to 0.

## Structure
- Shared package (v30mz_pkg) holds the state enum, segment index constants (SEG_PS/SS/DS0/DS1), and the prefix opcode constants.
- Sub-module opcode_format_decoder is combinational. Inputs are opcode and modrm; outputs are need_modrm, imm_size and is_prefix, following the NEC V30MZ opcode map.

## Test plan
- Stream 90 → one pop; the next cycle gives opcode 90, length 1, imm_size 0, pc unchanged until accept, then pc+1.
- Stream 2E 8B 46 FC → seg_override 0, opcode 8B, modrm 46, disp FFFC, length 4.
- Stream 81 06 34 12 78 56 with queue_empty toggling every other cycle → exactly 6 pops, disp 1234, imm 00005678, length 6.
- Stream F6 C0 55 then F6 D8 → first record imm 55, imm_size 1, length 3; second record imm_size 0, length 2.
- Flush with pc_load_value 0100 after 2 bytes of EA 00 10 00 F0 → no instr_valid for that instruction; pc=0100; the next byte decodes from S_OPCODE.
- instr_ready held low for 10 cycles at S_DONE with a non-empty queue → no pops and stable fields. Accept on cycle 11 → next pop on cycle 12.

Source files
------------

// File: rtl/v30mz_pkg.sv
// Shared types and constants for the V30MZ fetch/assembly front end.
// Holds the assembler state encoding, segment indices and prefix opcodes.
package v30mz_pkg;

  typedef enum logic [2:0] {
    S_OPCODE = 3'd0,
    S_MODRM  = 3'd1,
    S_DISP0  = 3'd2,
    S_DISP1  = 3'd3,
    S_IMM    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] SEG_PS  = 2'd0;
  localparam logic [1:0] SEG_SS  = 2'd1;
  localparam logic [1:0] SEG_DS0 = 2'd2;
  localparam logic [1:0] SEG_DS1 = 2'd3;

  localparam logic [7:0] PFX_DS1   = 8'h26;
  localparam logic [7:0] PFX_PS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS0   = 8'h3E;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  function automatic logic [1:0] seg_of_prefix(input logic [7:0] b);
    case (b)
      PFX_DS1: seg_of_prefix = SEG_DS1;
      PFX_SS:  seg_of_prefix = SEG_SS;
      PFX_DS0: seg_of_prefix = SEG_DS0;
      default: seg_of_prefix = SEG_PS;
    endcase
  endfunction

endpackage

// File: rtl/opcode_format_decoder.sv
// Opcode format decoder: ModRM need, immediate size, prefix and displacement size.
// Purely combinational, zero latency, no flow control.
module opcode_format_decoder
  import v30mz_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic [7:0] modrm,
  output logic       need_modrm,
  output logic [2:0] imm_size,
  output logic       is_prefix,
  output logic [1:0] disp_size
);

  always_comb begin
    need_modrm = 1'b0;
    if (opcode[7:6] == 2'b00 && !opcode[2]) need_modrm = 1'b1;
    casez (opcode)
      8'h62, 8'h69, 8'h6B,
      8'b1000_????, 8'b1100_000?, 8'b1100_01??,
      8'b1101_00??, 8'b1101_1???,
      8'hF6, 8'hF7, 8'hFE, 8'hFF: need_modrm = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    imm_size = 3'd0;
    // ALU accumulator-immediate forms x4/x5/xC/xD in the 00-3F block
    if (opcode[7:6] == 2'b00 && opcode[2:1] == 2'b10) imm_size = opcode[0] ? 3'd2 : 3'd1;
    casez (opcode)
      8'h6A, 8'h6B, 8'b0111_????, 8'h80, 8'h82, 8'h83, 8'hA8,
      8'b1011_0???, 8'hC0, 8'hC1, 8'hC6, 8'hCD, 8'hD4, 8'hD5,
      8'b1110_0???, 8'hEB:                                   imm_size = 3'd1;
      8'h68, 8'h69, 8'h81, 8'hA9, 8'b1010_00??, 8'b1011_1???,
      8'hC2, 8'hC7, 8'hCA, 8'hE8, 8'hE9:                     imm_size = 3'd2;
      8'hC8:                                                 imm_size = 3'd3;
      8'h9A, 8'hEA:                                          imm_size = 3'd4;
      8'hF6: imm_size = (modrm[5:3] == 3'b000) ? 3'd1 : 3'd0;
      8'hF7: imm_size = (modrm[5:3] == 3'b000) ? 3'd2 : 3'd0;
      default: ;
    endcase
  end

  always_comb begin
    is_prefix = 1'b0;
    case (opcode)
      PFX_DS1, PFX_PS, PFX_SS, PFX_DS0, PFX_LOCK, PFX_REPNE, PFX_REP: is_prefix = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    disp_size = 2'd0;
    case (modrm[7:6])
      2'b00:   if (modrm[2:0] == 3'b110) disp_size = 2'd2;
      2'b01:   disp_size = 2'd1;
      2'b10:   disp_size = 2'd2;
      default: disp_size = 2'd0;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Byte-serial instruction assembler; N pops then record valid next cycle, N+1 per instr.
// Stalls on queue_empty, holds record until instr_ready; V30MZ_PREFIX_EN merges prefixes.
module instruction_fetch_unit
  import v30mz_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  prefetch_data,
  input  logic        queue_empty,
  output logic        queue_pop,
  input  logic        flush,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic [15:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        seg_override_valid,
  output logic [1:0]  seg_override,
  output logic [1:0]  rep,
  output logic        lock,
  output logic [7:0]  opcode,
  output logic [7:0]  modrm,
  output logic [15:0] disp,
  output logic [31:0] imm,
  output logic [2:0]  imm_size,
  output logic [3:0]  length
);

`ifdef V30MZ_PREFIX_EN
  localparam bit PREFIX_EN = 1'b1;
`else
  localparam bit PREFIX_EN = 1'b0;
`endif

  state_t      state;
  logic [15:0] fetch_ptr;
  logic        disp_two;
  logic [1:0]  imm_idx;

  logic [7:0]  dec_opcode, dec_modrm;
  logic        dec_need_modrm, dec_is_prefix;
  logic [2:0]  dec_imm_size;
  logic [1:0]  dec_disp_size;

  assign dec_opcode  = (state == S_OPCODE) ? prefetch_data : opcode;
  assign dec_modrm   = (state == S_MODRM)  ? prefetch_data : modrm;
  assign instr_valid = (state == S_DONE);
  // Reset is folded in so a held reset never consumes queue bytes.
  assign queue_pop   = reset && (state != S_DONE) && !queue_empty && !flush;

  opcode_format_decoder u_dec (
    .opcode     (dec_opcode),
    .modrm      (dec_modrm),
    .need_modrm (dec_need_modrm),
    .imm_size   (dec_imm_size),
    .is_prefix  (dec_is_prefix),
    .disp_size  (dec_disp_size)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_OPCODE;  fetch_ptr <= '0;  pc <= '0;
      disp_two <= 1'b0;   imm_idx <= '0;
      seg_override_valid <= 1'b0;  seg_override <= '0;  rep <= '0;  lock <= 1'b0;
      opcode <= '0;  modrm <= '0;  disp <= '0;  imm <= '0;  imm_size <= '0;  length <= '0;
    end else if (flush || (state == S_DONE && instr_ready)) begin
      state <= S_OPCODE;
      disp_two <= 1'b0;   imm_idx <= '0;
      seg_override_valid <= 1'b0;  seg_override <= '0;  rep <= '0;  lock <= 1'b0;
      opcode <= '0;  modrm <= '0;  disp <= '0;  imm <= '0;  imm_size <= '0;  length <= '0;
      if (flush) begin
        // Without a load the refetch restarts at the aborted instruction.
        fetch_ptr <= pc_load ? pc_load_value : pc;
        if (pc_load) pc <= pc_load_value;
      end else begin
        pc <= fetch_ptr;
      end
    end else if (queue_pop) begin
      fetch_ptr <= fetch_ptr + 16'd1;
      length    <= (length == 4'd15) ? length : length + 4'd1;
      case (state)
        S_OPCODE: begin
          if (PREFIX_EN && dec_is_prefix) begin
            case (prefetch_data)
              PFX_LOCK:  lock <= 1'b1;
              PFX_REPNE: rep  <= 2'b10;
              PFX_REP:   rep  <= 2'b11;
              default: begin
                seg_override_valid <= 1'b1;
                seg_override       <= seg_of_prefix(prefetch_data);
              end
            endcase
          end else begin
            opcode   <= prefetch_data;
            imm_size <= dec_need_modrm ? 3'd0 : dec_imm_size;
            imm_idx  <= '0;
            if (dec_need_modrm)          state <= S_MODRM;
            else if (dec_imm_size != '0) state <= S_IMM;
            else                         state <= S_DONE;
          end
        end
        S_MODRM: begin
          modrm    <= prefetch_data;
          imm_size <= dec_imm_size;
          imm_idx  <= '0;
          disp_two <= (dec_disp_size == 2'd2);
          if (dec_disp_size != 2'd0)   state <= S_DISP0;
          else if (dec_imm_size != '0) state <= S_IMM;
          else                         state <= S_DONE;
        end
        S_DISP0: begin
          if (disp_two) begin
            disp[7:0] <= prefetch_data;
            state     <= S_DISP1;
          end else begin
            disp  <= {{8{prefetch_data[7]}}, prefetch_data};
            state <= (imm_size != '0) ? S_IMM : S_DONE;
          end
        end
        S_DISP1: begin
          disp[15:8] <= prefetch_data;
          state      <= (imm_size != '0) ? S_IMM : S_DONE;
        end
        S_IMM: begin
          imm[{imm_idx, 3'b000} +: 8] <= prefetch_data;
          imm_idx <= imm_idx + 2'd1;
          if (({1'b0, imm_idx} + 3'd1) == imm_size) state <= S_DONE;
        end
        default: state <= S_OPCODE;
      endcase
    end
  end

endmodule
